// File: rtl/uberlut_multi.sv
// uberlut_multi: loadable lookup table for Hotwright controller branch conditions.
// Entries are streamed in one per beat (valid/ready), then read back with a
// registered, valid-qualified lookup addressed by {varSel, variable}.
module uberlut_multi #(
  parameter int NUM_VARS        = 6,
  parameter int NUM_VARSEL      = 2,
  parameter int NUM_VARSEL_BITS = 3,
  parameter int OUT_WIDTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_restart,
  input  logic [OUT_WIDTH-1:0]       uberLUT_data,
  input  logic                       uberLUT_valid,
  output logic                       uberLUT_ready,
  output logic                       ready,
  input  logic                       lookup_valid,
  input  logic [NUM_VARS-1:0]        variable,
  input  logic [NUM_VARSEL_BITS-1:0] varSel,
  output logic [OUT_WIDTH-1:0]       lhs,
  output logic                       lhs_valid,
  output logic                       sel_err
);

  localparam int DEPTH = NUM_VARSEL * (2 ** NUM_VARS);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW    = NUM_VARSEL_BITS + NUM_VARS;

  localparam logic [CNT_W-1:0]         LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam logic [NUM_VARSEL_BITS:0] NSEL      = (NUM_VARSEL_BITS + 1)'(NUM_VARSEL);

  typedef enum logic [0:0] {
    LOADING = 1'b0,
    READY   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   load_addr_q, load_addr_d;
  logic               uready_s;
  logic               beat_acc_s;
  logic               wr_en_s;
  logic               ready_s;
  logic               lk_acc_s;
  logic               in_range_s;
  logic [AW-1:0]      addr_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [OUT_WIDTH-1:0] lhs_q;
  logic               lhs_valid_q;
  logic               sel_err_q;

  // Table storage; deliberately not reset so it can map onto block RAM.
  logic [OUT_WIDTH-1:0] mem [0:DEPTH-1];

  // Load FSM next state, beat acceptance and load address advance.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    uready_s    = 1'b0;
    beat_acc_s  = 1'b0;
    if (load_restart) begin
      // Restart wins over any beat presented in the same cycle.
      state_d     = LOADING;
      load_addr_d = '0;
    end else begin
      case (state_q)
        LOADING: begin
          uready_s = 1'b1;
          if (uberLUT_valid) begin
            beat_acc_s = 1'b1;
            if (load_addr_q == LAST_ADDR) begin
              state_d     = READY;
              load_addr_d = '0;
            end else begin
              load_addr_d = load_addr_q + CNT_W'(1);
            end
          end else begin
            load_addr_d = load_addr_q;
          end
        end
        READY: begin
          uready_s = 1'b0;
        end
        default: begin
          state_d     = LOADING;
          load_addr_d = '0;
        end
      endcase
    end
  end

  // Load FSM state and load address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOADING;
      load_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
    end
  end

  // Beats are never taken in the reset cycle, so ready is masked by rst too.
  assign uberLUT_ready = uready_s & ~rst;
  assign wr_en_s       = beat_acc_s & ~rst;
  assign wr_idx_s      = IDX_W'(load_addr_q);

  // Table write port, active only while loading.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_idx_s] <= uberLUT_data;
    end
  end

  assign ready_s    = (state_q == READY);
  assign ready      = ready_s;
  assign lk_acc_s   = lookup_valid & ready_s;
  assign addr_s     = {varSel, variable};
  assign in_range_s = ({1'b0, varSel} < NSEL);
  // In-range addresses are always below DEPTH, so the narrowing is lossless.
  assign rd_idx_s   = IDX_W'(addr_s);

  // Registered lookup: in-range reads the table, out-of-range flags sel_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      lhs_q       <= '0;
      lhs_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else if (lk_acc_s && in_range_s) begin
      lhs_q       <= mem[rd_idx_s];
      lhs_valid_q <= 1'b1;
      sel_err_q   <= 1'b0;
    end else if (lk_acc_s) begin
      lhs_q       <= '0;
      lhs_valid_q <= 1'b1;
      sel_err_q   <= 1'b1;
    end else begin
      lhs_q       <= lhs_q;
      lhs_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end
  end

  assign lhs       = lhs_q;
  assign lhs_valid = lhs_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_uberlut_multi.sv
// Self-checking bench for uberlut_multi (NUM_VARS=2, NUM_VARSEL=3, DEPTH=12).
// A count-based reference model predicts every output each cycle.
module tb_uberlut_multi;

  localparam int NV    = 2;
  localparam int NS    = 3;
  localparam int NSB   = 2;
  localparam int OW    = 4;
  localparam int DEPTH = NS * (2 ** NV);

  logic          clk;
  logic          rst;
  logic          load_restart;
  logic [OW-1:0] uberLUT_data;
  logic          uberLUT_valid;
  logic          uberLUT_ready;
  logic          ready;
  logic          lookup_valid;
  logic [NV-1:0] variable;
  logic [NSB-1:0] varSel;
  logic [OW-1:0] lhs;
  logic          lhs_valid;
  logic          sel_err;

  uberlut_multi #(
    .NUM_VARS(NV), .NUM_VARSEL(NS), .NUM_VARSEL_BITS(NSB), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .load_restart(load_restart),
    .uberLUT_data(uberLUT_data), .uberLUT_valid(uberLUT_valid),
    .uberLUT_ready(uberLUT_ready), .ready(ready),
    .lookup_valid(lookup_valid), .variable(variable), .varSel(varSel),
    .lhs(lhs), .lhs_valid(lhs_valid), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_mem [DEPTH];
  int m_count;
  bit m_ready;
  int m_lhs;
  bit m_lv;
  bit m_se;
  bit chk_en;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the inputs currently driven at the next rising edge.
  function automatic void model_step();
    if (rst) begin
      m_ready = 1'b0;
      m_count = 0;
      m_lhs   = 0;
      m_lv    = 1'b0;
      m_se    = 1'b0;
      return;
    end
    if (lookup_valid && m_ready) begin
      m_lv = 1'b1;
      if (int'(varSel) < NS) begin
        m_lhs = m_mem[int'(varSel) * (2 ** NV) + int'(variable)];
        m_se  = 1'b0;
      end else begin
        m_lhs = 0;
        m_se  = 1'b1;
      end
    end else begin
      m_lv = 1'b0;
      m_se = 1'b0;
    end
    if (load_restart) begin
      m_ready = 1'b0;
      m_count = 0;
    end else if (!m_ready && uberLUT_valid) begin
      m_mem[m_count] = int'(uberLUT_data);
      m_count++;
      if (m_count == DEPTH) begin
        m_ready = 1'b1;
        m_count = 0;
      end
    end
  endfunction

  task automatic cycle();
    #1;
    if (chk_en) chk("uready", {31'd0, uberLUT_ready}, {31'd0, (!m_ready && !rst && !load_restart)});
    @(posedge clk);
    model_step();
    #1;
    if (chk_en) begin
      chk("ready", {31'd0, ready}, {31'd0, m_ready});
      chk("lhs_valid", {31'd0, lhs_valid}, {31'd0, m_lv});
      chk("sel_err", {31'd0, sel_err}, {31'd0, m_se});
      chk("lhs", {28'd0, lhs}, m_lhs[31:0]);
    end
  endtask

  task automatic idle();
    rst = 1'b0; load_restart = 1'b0; uberLUT_valid = 1'b0;
    lookup_valid = 1'b0; uberLUT_data = 4'd0; varSel = 2'd0; variable = 2'd0;
  endtask

  task automatic lookup(input int s, input int v);
    lookup_valid = 1'b1;
    varSel       = s[NSB-1:0];
    variable     = v[NV-1:0];
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    m_count = 0; m_ready = 1'b0; m_lhs = 0; m_lv = 1'b0; m_se = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 0;
    idle();
    rst = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle();
    chk("rst_lhs", {28'd0, lhs}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);

    // 1. Basic load, data = index
    idle();
    uberLUT_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      uberLUT_data = i[OW-1:0];
      if (i == DEPTH - 1) chk("t1_ready_low", {31'd0, ready}, 32'd0);
      cycle();
    end
    uberLUT_valid = 1'b0;
    chk("t1_ready", {31'd0, ready}, 32'd1);
    lookup(2, 3);
    cycle();
    chk("t1_lhs", {28'd0, lhs}, 32'd11);
    chk("t1_lv", {31'd0, lhs_valid}, 32'd1);

    // 2. Back-to-back lookups
    lookup(0, 1); cycle(); chk("t2_a", {28'd0, lhs}, 32'd1);
    lookup(1, 0); cycle(); chk("t2_b", {28'd0, lhs}, 32'd4);
    lookup(2, 2); cycle(); chk("t2_c", {28'd0, lhs}, 32'd10);
    chk("t2_lv", {31'd0, lhs_valid}, 32'd1);

    // 3. Out-of-range select
    lookup(3, 0); cycle();
    chk("t3_lhs", {28'd0, lhs}, 32'd0);
    chk("t3_se", {31'd0, sel_err}, 32'd1);
    chk("t3_lv", {31'd0, lhs_valid}, 32'd1);
    idle(); cycle();
    chk("t3_se_idle", {31'd0, sel_err}, 32'd0);

    // 4. Restart, gapped load with early lookups, extra beats in READY
    load_restart = 1'b1; cycle();
    load_restart = 1'b0;
    chk("t4_ready_drop", {31'd0, ready}, 32'd0);
    begin
      int beat;
      beat = 0;
      for (int i = 0; i <= 22; i++) begin
        uberLUT_valid = (i % 2 == 0);
        uberLUT_data  = beat[OW-1:0];
        lookup($urandom_range(0, 3), $urandom_range(0, 3));
        cycle();
        if (i % 2 == 0) beat++;
        chk("t4_early_lv", {31'd0, lhs_valid}, 32'd0);
        if (i < 22) chk("t4_not_ready", {31'd0, ready}, 32'd0);
      end
    end
    chk("t4_ready", {31'd0, ready}, 32'd1);
    idle();
    uberLUT_valid = 1'b1; uberLUT_data = 4'hF;
    for (int i = 0; i < 3; i++) cycle();
    idle();
    lookup(0, 0); cycle();
    chk("t4_addr0", {28'd0, lhs}, 32'd0);

    // 5. Restart in READY with a dropped beat and an old-content lookup
    load_restart = 1'b1; uberLUT_valid = 1'b1; uberLUT_data = 4'd5;
    lookup(2, 3);
    cycle();
    chk("t5_ready_drop", {31'd0, ready}, 32'd0);
    chk("t5_old", {28'd0, lhs}, 32'd11);
    idle();
    uberLUT_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      uberLUT_data = 4'(11 - i);
      cycle();
    end
    idle();
    lookup(0, 0); cycle(); chk("t5_addr0", {28'd0, lhs}, 32'd11);
    lookup(2, 3); cycle(); chk("t5_addr11", {28'd0, lhs}, 32'd0);

    // 6. Reset mid-load
    idle();
    load_restart = 1'b1; cycle();
    idle();
    uberLUT_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      uberLUT_data = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b1; cycle();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      uberLUT_data = 4'($urandom_range(0, 15));
      cycle();
      if (i < DEPTH - 1) chk("t6_not_ready", {31'd0, ready}, 32'd0);
    end
    chk("t6_ready", {31'd0, ready}, 32'd1);
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      lookup(a / 4, a % 4);
      cycle();
    end

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      load_restart  = ($urandom_range(0, 47) == 0);
      uberLUT_valid = $urandom_range(0, 1) != 0;
      uberLUT_data  = 4'($urandom_range(0, 15));
      lookup_valid  = $urandom_range(0, 1) != 0;
      varSel        = 2'($urandom_range(0, 3));
      variable      = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uberlut_multi.md
# uberlut_multi

Parametrised successor to the single-bit UberLUT: a loadable lookup table holding the condition logic of `if` statements for the Hotwright controller. It stores `NUM_VARSEL*2**NUM_VARS` entries of `OUT_WIDTH` bits each. Entries are loaded one per beat over a valid/ready stream and read back with a registered, valid-qualified lookup. Compared with its predecessor it adds multi-bit entries, load backpressure, in-place reload, out-of-range select detection and a one-cycle pipelined read. It sits between the microcode sequencer (supplies `varSel` and `variable`) and the branch logic (consumes `lhs`).

## Interface
Parameters:
- NUM_VARS, 6: number of condition variable bits; low address field.
- NUM_VARSEL, 2: number of valid variable-select banks.
- NUM_VARSEL_BITS, 3: width of `varSel`; must satisfy `2**NUM_VARSEL_BITS >= NUM_VARSEL`.
- OUT_WIDTH, 4: bits per entry; `lhs` width.
- Derived DEPTH = `NUM_VARSEL*2**NUM_VARS`.
- Derived CNT_W = `$clog2(DEPTH+1)`.

Ports:
- clk, in, 1: the single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- load_restart, in, 1: single-cycle pulse; restarts loading at entry 0.
- uberLUT_data, in, OUT_WIDTH: load beat payload, one entry.
- uberLUT_valid, in, 1: payload valid.
- uberLUT_ready, out, 1: table accepts a beat.
- ready, out, 1: table fully loaded; lookups enabled.
- lookup_valid, in, 1: lookup request this cycle.
- variable, in, NUM_VARS: condition variable values.
- varSel, in, NUM_VARSEL_BITS: bank select.
- lhs, out, OUT_WIDTH: registered lookup result.
- lhs_valid, out, 1: `lhs` valid, one cycle per accepted lookup.
- sel_err, out, 1: registered with `lhs_valid`; the request used `varSel >= NUM_VARSEL`.

## Operation
- **Storage.** DEPTH x OUT_WIDTH array, inferable as block RAM. Contents are not cleared by reset.
- **Load FSM, LOADING state.**
  - `uberLUT_ready = 1`, `ready = 0`.
  - A beat is accepted when `uberLUT_valid && uberLUT_ready`: the payload is written to `mem[load_addr]` and `load_addr` increments.
  - Accepting the beat at `load_addr == DEPTH-1` moves the FSM to READY.
- **Load FSM, READY state.**
  - `uberLUT_ready = 0`, `ready = 1`.
  - Beats presented while in READY are not accepted and do not alter the table.
- **Reset.** `rst` puts the FSM in LOADING with `load_addr = 0`.
- **Restart.** `load_restart` in either state puts the FSM in LOADING with `load_addr = 0`. A beat presented in the same cycle is dropped; `uberLUT_ready` is 0 in that cycle.
- **Address.** Lookup address = `{varSel, variable}`. Width is NUM_VARSEL_BITS+NUM_VARS. Only `varSel < NUM_VARSEL` is in range.
- **Lookup acceptance.** A lookup is accepted only when `lookup_valid && ready`.
- **Lookup response.** The next cycle has `lhs_valid = 1` and `lhs = mem[addr]`.
- **Out-of-range select.** If `varSel >= NUM_VARSEL`, the response has `lhs = 0` and `sel_err = 1`; memory is not read out of range.
- **Lookups while not ready.** Lookups with `ready = 0` are ignored: `lhs_valid = 0` next cycle.
- **Holding values.** `lhs` holds its last value when `lhs_valid = 0`. `sel_err` is 0 whenever `lhs_valid = 0`.

## Timing
- **Reset values:**
  - `uberLUT_ready = 1` (LOADING; held 0 in the reset cycle itself).
  - `ready = 0`.
  - `lhs = 0`.
  - `lhs_valid = 0`.
  - `sel_err = 0`.
- **Reset mid-operation.**
  - A reset mid-load discards progress.
  - A reset in READY drops `ready` the next cycle.
  - A lookup accepted in the reset cycle produces no response.
- **Load throughput.** One beat per cycle. A full load takes DEPTH accepted beats.
- **Ready timing.** `ready` rises the cycle after the final beat is accepted.
- **Lookup timing.** Latency 1 cycle, one lookup per cycle, fully pipelined.
- **Restart in READY.**
  - `ready` falls the cycle after `load_restart`.
  - A lookup in the restart cycle is still accepted, since `ready` was 1 that cycle, and returns the old contents.
- **Write/read hazard.** None: writes occur only in LOADING and reads only in READY.
- **Counter width.** `load_addr` is CNT_W bits wide and never exceeds DEPTH-1 while in LOADING; there is no wrap.

## Test plan
Configuration for all scenarios: NUM_VARS=2, NUM_VARSEL=3, NUM_VARSEL_BITS=2, OUT_WIDTH=4, giving DEPTH=12.

1. **Basic load.** After reset, stream 12 beats with data = index (0..11), valid held high.
   - Required: `uberLUT_ready = 1` for 12 cycles; `ready` rises the cycle after beat 11 and `uberLUT_ready` falls.
   - Then issue lookup `varSel=2`, `variable=3`.
   - Required: next cycle `lhs_valid = 1`, `lhs = 11`, `sel_err = 0`.
2. **Back-to-back lookups.** Issue `varSel=0/var=1`, then `varSel=1/var=0`, then `varSel=2/var=2` in consecutive cycles.
   - Required: `lhs` = 1, 4, 10 on three consecutive cycles with `lhs_valid` high throughout.
3. **Out-of-range select and early lookups.**
   - Lookup `varSel=3`, `variable=0`: `lhs = 0`, `sel_err = 1`, `lhs_valid = 1`.
   - Lookups before load completes: `lhs_valid` stays 0.
4. **Backpressure.** Load gapped with `uberLUT_valid` toggling every cycle.
   - Required: `ready` only after the 12th accepted beat.
   - Extra beats in READY (data 0xF): table unchanged; a lookup at address 0 returns 0.
5. **Reload.** Pulse `load_restart` in READY.
   - Required: `ready` = 0 next cycle.
   - Reload 12 beats of `11 - index`; lookup address 0 returns 11.
   - A beat presented with the restart pulse is dropped.
6. **Reset mid-load.** Assert `rst` after 5 beats.
   - Required: next 12 beats are written from address 0; `ready` only after all 12.
